bs_job_controller: RTL and testbench

- Parametrised command/status controller for the Black-Scholes compute path.
- Takes a host command nibble and snapshots NUM_CONST constants of DATA_W bits. It launches an external pricing engine with a start/done handshake and captures the engine result.
- Terminates a job on completion, engine error, timeout or host abort, and reports status until the host acknowledges.

---
 rtl/bs_job_controller_if.sv | 23 ++
 rtl/bs_job_controller.sv | 97 +++++++++
 tb/tb_bs_job_controller.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bs_job_controller_if.sv
// Engine-side handshake bundle for bs_job_controller: launch/cancel pulses,
// snapshotted constants out, done/error/result back from the pricing engine.
interface bs_job_controller_if #(
  parameter int DATA_W    = 32,
  parameter int NUM_CONST = 4
);
  logic                          eng_start;
  logic                          eng_abort;
  logic [NUM_CONST*DATA_W-1:0]   eng_const;
  logic                          eng_done;
  logic                          eng_error;
  logic [DATA_W-1:0]             eng_result;

  modport master (
    output eng_start, eng_abort, eng_const,
    input  eng_done, eng_error, eng_result
  );

  modport slave (
    input  eng_start, eng_abort, eng_const,
    output eng_done, eng_error, eng_result
  );
endinterface

// File: rtl/bs_job_controller.sv
// Host command/status controller that launches the Black-Scholes pricing engine,
// supervises it (done, error, abort, timeout) and holds the job report until ACK.
module bs_job_controller #(
  parameter int DATA_W    = 32,
  parameter int NUM_CONST = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3:0]                  cmd,
  input  logic [NUM_CONST*DATA_W-1:0] const_in,
  input  logic [TIMEOUT_W-1:0]        timeout_limit,
  bs_job_controller_if.master         eng,
  output logic [3:0]                  status,
  output logic [1:0]                  err_code,
  output logic [DATA_W-1:0]           dout,
  output logic [TIMEOUT_W-1:0]        cycles
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUNNING  = 2'd1,
    S_COMPLETE = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  localparam logic [3:0]           CMD_RUN   = 4'd1;
  localparam logic [3:0]           CMD_ACK   = 4'd2;
  localparam logic [3:0]           CMD_ABORT = 4'd3;
  localparam logic [TIMEOUT_W-1:0] CYC_ONE   = TIMEOUT_W'(1);

  state_t               state;
  logic [TIMEOUT_W-1:0] cycles_inc;
  logic                 timeout_hit;

  assign cycles_inc  = (&cycles) ? cycles : cycles + CYC_ONE;
  assign timeout_hit = (timeout_limit != '0) && (cycles == timeout_limit - CYC_ONE);
  assign status      = {2'b00, state};

  // eng_start doubles as the "first RUNNING cycle" marker, during which engine
  // feedback is ignored. A timeout counts its final cycle so cycles reads back
  // as the limit itself; other terminations leave the counter untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      eng.eng_start <= 1'b0;
      eng.eng_abort <= 1'b0;
      eng.eng_const <= '0;
      err_code      <= 2'd0;
      dout          <= '0;
      cycles        <= '0;
    end else begin
      eng.eng_start <= 1'b0;
      eng.eng_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          eng.eng_const <= const_in;
          if (cmd == CMD_RUN) begin
            state         <= S_RUNNING;
            dout          <= '0;
            cycles        <= '0;
            err_code      <= 2'd0;
            eng.eng_start <= 1'b1;
          end
        end
        S_RUNNING: begin
          if (eng.eng_start) begin
            cycles <= cycles_inc;
          end else if (eng.eng_error) begin
            state    <= S_ERROR;
            err_code <= 2'd1;
          end else if (eng.eng_done) begin
            state <= S_COMPLETE;
            dout  <= eng.eng_result;
          end else if (cmd == CMD_ABORT) begin
            state         <= S_IDLE;
            eng.eng_abort <= 1'b1;
          end else if (timeout_hit) begin
            state         <= S_ERROR;
            err_code      <= 2'd2;
            eng.eng_abort <= 1'b1;
            cycles        <= cycles_inc;
          end else begin
            cycles <= cycles_inc;
          end
        end
        S_COMPLETE, S_ERROR: begin
          if (cmd == CMD_ACK) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bs_job_controller.sv
// Self-checking bench for bs_job_controller: vector table, hand-written corner
// sequences and randomized traffic against a job-level reference model.
module tb_bs_job_controller;
  localparam int DATA_W    = 32;
  localparam int NUM_CONST = 4;
  localparam int TIMEOUT_W = 16;
  localparam int CW        = NUM_CONST * DATA_W;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [3:0]           cmd;
  logic [CW-1:0]        const_in;
  logic [TIMEOUT_W-1:0] timeout_limit;
  logic [3:0]           status;
  logic [1:0]           err_code;
  logic [DATA_W-1:0]    dout;
  logic [TIMEOUT_W-1:0] cycles;

  bs_job_controller_if #(.DATA_W(DATA_W), .NUM_CONST(NUM_CONST)) eng ();

  bs_job_controller #(
    .DATA_W(DATA_W), .NUM_CONST(NUM_CONST), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .const_in(const_in),
    .timeout_limit(timeout_limit), .eng(eng), .status(status),
    .err_code(err_code), .dout(dout), .cycles(cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: job-level view; m_age is the 1-based index of the current RUNNING cycle.
  int                   m_state;
  int                   m_age;
  logic [DATA_W-1:0]    m_dout;
  logic [1:0]           m_err;
  logic [TIMEOUT_W-1:0] m_cycles;
  logic [CW-1:0]        m_const;
  logic                 m_start;
  logic                 m_abort;

  typedef struct packed {
    logic [3:0]           c;
    logic                 d;
    logic                 e;
    logic [DATA_W-1:0]    r;
    logic [CW-1:0]        k;
    logic [3:0]           st;
    logic                 s;
    logic                 ab;
    logic [DATA_W-1:0]    dv;
    logic [TIMEOUT_W-1:0] cyc;
    logic [1:0]           err;
    logic [CW-1:0]        kx;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [TIMEOUT_W-1:0] satCount(input int n);
    if (n >= (1 << TIMEOUT_W) - 1) return '1;
    return TIMEOUT_W'(n);
  endfunction

  task automatic modelReset();
    m_state = 0; m_age = 0; m_dout = '0; m_err = 2'd0;
    m_cycles = '0; m_const = '0; m_start = 1'b0; m_abort = 1'b0;
  endtask

  task automatic modelStep(input logic [3:0] c, input logic d, input logic e,
                           input logic [DATA_W-1:0] r);
    bit later;
    m_start = 1'b0;
    m_abort = 1'b0;
    case (m_state)
      0: begin
        m_const = const_in;
        if (c == 4'd1) begin
          m_state = 1; m_age = 1; m_cycles = '0; m_dout = '0; m_err = 2'd0; m_start = 1'b1;
        end
      end
      1: begin
        later = (m_age > 1);
        if (later && e) begin
          m_state = 3; m_err = 2'd1;
        end else if (later && d) begin
          m_state = 2; m_dout = r;
        end else if (later && c == 4'd3) begin
          m_state = 0; m_abort = 1'b1;
        end else if (later && timeout_limit != 0 && m_age == int'(timeout_limit)) begin
          m_state = 3; m_err = 2'd2; m_abort = 1'b1; m_cycles = satCount(m_age);
        end else begin
          m_cycles = satCount(m_age);
          m_age++;
        end
      end
      default: if (c == 4'd2) m_state = 0;
    endcase
  endtask

  task automatic checkField(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkField({tag, " status"},    status,        128'(m_state));
    checkField({tag, " err_code"},  err_code,      m_err);
    checkField({tag, " dout"},      dout,          m_dout);
    checkField({tag, " cycles"},    cycles,        m_cycles);
    checkField({tag, " eng_start"}, eng.eng_start, m_start);
    checkField({tag, " eng_abort"}, eng.eng_abort, m_abort);
    checkField({tag, " eng_const"}, eng.eng_const, m_const);
  endtask

  task automatic applyStimulus(input logic [3:0] c, input logic d, input logic e,
                               input logic [DATA_W-1:0] r);
    cmd = c;
    eng.eng_done = d;
    eng.eng_error = e;
    eng.eng_result = r;
    modelStep(c, d, e, r);
    @(posedge clk);
    #1;
    checkOutput("model");
  endtask

  task automatic addRow(input logic [3:0] c, input logic d, input logic e, input logic [31:0] r,
                        input logic [CW-1:0] k, input logic [3:0] st, input logic s, input logic ab,
                        input logic [31:0] dv, input logic [15:0] cyc, input logic [1:0] err,
                        input logic [CW-1:0] kx);
    vec_t v;
    v.c = c; v.d = d; v.e = e; v.r = r; v.k = k; v.st = st; v.s = s; v.ab = ab;
    v.dv = dv; v.cyc = cyc; v.err = err; v.kx = kx;
    tbl.push_back(v);
  endtask

  initial begin
    logic [CW-1:0] c1;
    logic [CW-1:0] cf;
    int sel;
    logic [3:0] rc;
    c1 = {32'd4, 32'd3, 32'd2, 32'd1};
    cf = '1;

    //      cmd d  e  result        const st s  ab dout          cyc err expConst
    addRow(1, 0, 0, 0,            c1, 1, 1, 0, 0,            0, 0, c1);
    addRow(0, 0, 0, 0,            cf, 1, 0, 0, 0,            1, 0, c1);
    addRow(0, 0, 0, 0,            c1, 1, 0, 0, 0,            2, 0, c1);
    addRow(0, 0, 0, 0,            c1, 1, 0, 0, 0,            3, 0, c1);
    addRow(0, 0, 0, 0,            c1, 1, 0, 0, 0,            4, 0, c1);
    addRow(0, 0, 0, 0,            c1, 1, 0, 0, 0,            5, 0, c1);
    addRow(0, 1, 0, 32'h12345678, c1, 2, 0, 0, 32'h12345678, 5, 0, c1);
    addRow(1, 1, 1, 32'h0,        c1, 2, 0, 0, 32'h12345678, 5, 0, c1);
    addRow(2, 0, 0, 0,            cf, 0, 0, 0, 32'h12345678, 5, 0, c1);
    addRow(0, 0, 0, 0,            cf, 0, 0, 0, 32'h12345678, 5, 0, cf);
    addRow(3, 0, 0, 0,            c1, 0, 0, 0, 32'h12345678, 5, 0, c1);
    addRow(1, 0, 0, 0,            c1, 1, 1, 0, 0,            0, 0, c1);
    addRow(0, 1, 1, 32'hBEEF,     c1, 1, 0, 0, 0,            1, 0, c1);
    addRow(0, 1, 1, 32'hDEAD,     c1, 3, 0, 0, 0,            1, 1, c1);
    addRow(2, 0, 0, 0,            c1, 0, 0, 0, 0,            1, 1, c1);
    addRow(1, 0, 0, 0,            c1, 1, 1, 0, 0,            0, 0, c1);
    addRow(2, 0, 0, 0,            c1, 1, 0, 0, 0,            1, 0, c1);
    addRow(1, 0, 0, 0,            c1, 1, 0, 0, 0,            2, 0, c1);
    addRow(3, 0, 0, 0,            c1, 0, 0, 1, 0,            2, 0, c1);
    addRow(0, 0, 0, 0,            c1, 0, 0, 0, 0,            2, 0, c1);
    addRow(1, 0, 0, 0,            c1, 1, 1, 0, 0,            0, 0, c1);
    addRow(0, 0, 0, 0,            c1, 1, 0, 0, 0,            1, 0, c1);
    addRow(3, 1, 0, 32'h55,       c1, 2, 0, 0, 32'h55,       1, 0, c1);
    addRow(2, 0, 0, 0,            c1, 0, 0, 0, 32'h55,       1, 0, c1);

    reset = 1'b1;
    cmd = 4'd0;
    const_in = '0;
    timeout_limit = '0;
    eng.eng_done = 1'b0;
    eng.eng_error = 1'b0;
    eng.eng_result = '0;
    modelReset();
    #12;
    checkOutput("reset");
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      const_in = tbl[i].k;
      applyStimulus(tbl[i].c, tbl[i].d, tbl[i].e, tbl[i].r);
      checkField($sformatf("row%0d status", i),    status,        tbl[i].st);
      checkField($sformatf("row%0d eng_start", i), eng.eng_start, tbl[i].s);
      checkField($sformatf("row%0d eng_abort", i), eng.eng_abort, tbl[i].ab);
      checkField($sformatf("row%0d dout", i),      dout,          tbl[i].dv);
      checkField($sformatf("row%0d cycles", i),    cycles,        tbl[i].cyc);
      checkField($sformatf("row%0d err_code", i),  err_code,      tbl[i].err);
      checkField($sformatf("row%0d eng_const", i), eng.eng_const, tbl[i].kx);
    end

    // Timeout at limit 10 with a silent engine
    timeout_limit = 16'd10;
    applyStimulus(1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkField("timeout running", status, 4'd1);
      checkField("timeout count", cycles, 128'(i));
    end
    applyStimulus(0, 0, 0, 0);
    checkField("timeout status", status, 4'd3);
    checkField("timeout err", err_code, 2'd2);
    checkField("timeout cycles", cycles, 16'd10);
    checkField("timeout abort", eng.eng_abort, 1'b1);
    applyStimulus(0, 0, 0, 0);
    checkField("timeout abort end", eng.eng_abort, 1'b0);
    applyStimulus(2, 0, 0, 0);
    checkField("ack status", status, 4'd0);
    checkField("ack err held", err_code, 2'd2);
    applyStimulus(1, 0, 0, 0);
    checkField("rerun err clear", err_code, 2'd0);
    checkField("rerun cycles clear", cycles, 16'd0);

    // Live limit changes: lowering below the count must not fire
    timeout_limit = 16'd0;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    timeout_limit = 16'd2;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    checkField("lowered limit no fire", status, 4'd1);
    timeout_limit = 16'd8;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkField("raised limit fires", status, 4'd3);
    checkField("raised limit cycles", cycles, 16'd8);
    applyStimulus(2, 0, 0, 0);
    timeout_limit = 16'd0;

    // Asynchronous reset in the middle of a RUNNING cycle
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkField("async status", status, 4'd0);
    checkField("async cycles", cycles, 16'd0);
    checkField("async const", eng.eng_const, 128'd0);
    checkField("async abort", eng.eng_abort, 1'b0);
    checkOutput("async");
    @(posedge clk);
    #2 reset = 1'b0;
    applyStimulus(1, 0, 0, 0);
    checkField("post-reset start", eng.eng_start, 1'b1);

    // Back-to-back: ACK then RUN yields eng_start two edges after ACK
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 32'hCAFE);
    applyStimulus(2, 0, 0, 0);
    checkField("b2b idle", eng.eng_start, 1'b0);
    applyStimulus(1, 0, 0, 0);
    checkField("b2b start", eng.eng_start, 1'b1);
    applyStimulus(3, 0, 0, 0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      if (n % 40 == 0) begin
        sel = $urandom_range(0, 3);
        timeout_limit = (sel == 0) ? 16'd0 : TIMEOUT_W'($urandom_range(1, 20));
      end
      const_in = {$urandom, $urandom, $urandom, $urandom};
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    rc = 4'd1;
        2, 3:    rc = 4'd2;
        4:       rc = 4'd3;
        5:       rc = 4'($urandom_range(4, 15));
        default: rc = 4'd0;
      endcase
      applyStimulus(rc, $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
